// File: rtl/caf_pkg.sv
// Shared types and default widths for the CAF peak-detection datapath.
package caf_pkg;

    typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} caf_state_e;

    localparam int CAF_SAMPLE_W = 24;
    localparam int CAF_MAG_W    = 48;

    function automatic int caf_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cpx_mag_sq.sv
// Three-stage |z|^2 = i^2 + q^2 pipeline carrying a valid bit and an opaque tag.
module cpx_mag_sq
    import caf_pkg::*;
#(
    parameter int i_bits   = CAF_SAMPLE_W,
    parameter int q_bits   = CAF_SAMPLE_W,
    parameter int mag_bits = CAF_MAG_W,
    parameter int tag_bits = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       vld,
    input  logic signed [i_bits-1:0]   i,
    input  logic signed [q_bits-1:0]   q,
    input  logic        [tag_bits-1:0] tag,
    output logic                       vld_out,
    output logic        [mag_bits-1:0] mag,
    output logic        [tag_bits-1:0] tag_out
);

    localparam int SW = caf_max(i_bits, q_bits);
    localparam int PW = 2 * SW;

    logic                       vld_p0, vld_p1, vld_p2;
    logic        [tag_bits-1:0] tag_p0, tag_p1, tag_p2;
    logic signed [SW-1:0]       i_p0, q_p0;
    logic signed [PW-1:0]       i_sq_p1, q_sq_p1;
    logic        [mag_bits-1:0] mag_p2;

    // Both squares are non-negative, so their sum fits PW bits unsigned.
    function automatic logic [mag_bits-1:0] mag_sum(input logic signed [PW-1:0] a,
                                                    input logic signed [PW-1:0] b);
        logic [PW-1:0] s;
        s = $unsigned(a) + $unsigned(b);
        return mag_bits'(s);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            tag_p0  <= '0;
            tag_p1  <= '0;
            tag_p2  <= '0;
            i_p0    <= '0;
            q_p0    <= '0;
            i_sq_p1 <= '0;
            q_sq_p1 <= '0;
            mag_p2  <= '0;
        end else begin
            // p0: operands sign-extended to a common width
            vld_p0  <= vld;
            tag_p0  <= tag;
            i_p0    <= SW'(i);
            q_p0    <= SW'(q);
            // p1: full-precision signed squares
            vld_p1  <= vld_p0;
            tag_p1  <= tag_p0;
            i_sq_p1 <= PW'(i_p0) * PW'(i_p0);
            q_sq_p1 <= PW'(q_p0) * PW'(q_p0);
            // p2: zero-extended sum
            vld_p2  <= vld_p1;
            tag_p2  <= tag_p1;
            mag_p2  <= mag_sum(i_sq_p1, q_sq_p1);
        end
    end

    assign vld_out = vld_p2;
    assign mag     = mag_p2;
    assign tag_out = tag_p2;

endmodule

// File: rtl/caf_peak_detect.sv
// Per-bin frame peak detector: tags accepted results, tracks the largest |z|^2
// over num_results inputs and presents it on a valid/ready output.
module caf_peak_detect
    import caf_pkg::*;
#(
    parameter int i_bits      = CAF_SAMPLE_W,
    parameter int q_bits      = CAF_SAMPLE_W,
    parameter int mag_bits    = CAF_MAG_W,
    parameter int num_results = 16,
    parameter int index_bits  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_axis_product_tvalid,
    input  logic signed [i_bits-1:0]     i,
    input  logic signed [q_bits-1:0]     q,
    output logic                         m_axis_product_tready,
    input  logic                         m_axis_peak_tready,
    output logic                         s_axis_peak_tvalid,
    output logic        [mag_bits-1:0]   peak_mag,
    output logic        [index_bits-1:0] peak_index,
    output logic                         overflow
);

    localparam logic [index_bits-1:0] LAST_IDX = index_bits'(num_results - 1);

    caf_state_e              state;
    logic                    accept;
    logic [index_bits-1:0]   in_count;
    logic                    cmp_vld;
    logic [mag_bits-1:0]     cmp_mag;
    logic [index_bits-1:0]   cmp_tag;
    logic [mag_bits-1:0]     max_mag;
    logic [index_bits-1:0]   max_idx;
    logic                    last_done;

    assign accept = s_axis_product_tvalid && m_axis_product_tready;

    cpx_mag_sq #(
        .i_bits   (i_bits),
        .q_bits   (q_bits),
        .mag_bits (mag_bits),
        .tag_bits (index_bits)
    ) u_mag_sq (
        .clk     (clk),
        .rst_n   (rst_n),
        .vld     (accept),
        .i       (i),
        .q       (q),
        .tag     (in_count),
        .vld_out (cmp_vld),
        .mag     (cmp_mag),
        .tag_out (cmp_tag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_count <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= s_axis_product_tvalid && !m_axis_product_tready;
            if (accept)
                in_count <= (in_count == LAST_IDX) ? '0 : in_count + 1'b1;
        end
    end

    // Tag 0 seeds the frame; later tags need a strictly larger magnitude, so ties keep the first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_mag   <= '0;
            max_idx   <= '0;
            last_done <= 1'b0;
        end else begin
            last_done <= cmp_vld && (cmp_tag == LAST_IDX);
            if (cmp_vld && ((cmp_tag == '0) || (cmp_mag > max_mag))) begin
                max_mag <= cmp_mag;
                max_idx <= cmp_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= ACCUM;
            m_axis_product_tready <= 1'b1;
            s_axis_peak_tvalid    <= 1'b0;
            peak_mag              <= '0;
            peak_index            <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept && (in_count == LAST_IDX)) begin
                        m_axis_product_tready <= 1'b0;
                        state                 <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_done) begin
                        peak_mag           <= max_mag;
                        peak_index         <= max_idx;
                        s_axis_peak_tvalid <= 1'b1;
                        state              <= HOLD;
                    end
                end
                HOLD: begin
                    if (s_axis_peak_tvalid && m_axis_peak_tready) begin
                        s_axis_peak_tvalid    <= 1'b0;
                        m_axis_product_tready <= 1'b1;
                        state                 <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_caf_peak_detect.sv
// Bench for caf_peak_detect: frame-level reference model plus directed and random frames.
`timescale 1ns/1ps
module tb_caf_peak_detect;

    localparam int IW = 24;
    localparam int QW = 24;
    localparam int MW = 48;
    localparam int NR = 16;
    localparam int IB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                 s_vld = 1'b0;
    logic signed [IW-1:0] di = '0;
    logic signed [QW-1:0] dq = '0;
    logic                 m_ready = 1'b0;
    logic                 tready, pvalid, ovf;
    logic [MW-1:0]        pmag;
    logic [IB-1:0]        pidx;

    logic                 s1_vld = 1'b0;
    logic signed [IW-1:0] di1 = '0;
    logic signed [QW-1:0] dq1 = '0;
    logic                 m1_ready = 1'b0;
    logic                 tready1, pvalid1, ovf1;
    logic [MW-1:0]        pmag1;
    logic [0:0]           pidx1;

    caf_peak_detect #(
        .i_bits(IW), .q_bits(QW), .mag_bits(MW), .num_results(NR), .index_bits(IB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_product_tvalid(s_vld), .i(di), .q(dq),
        .m_axis_product_tready(tready), .m_axis_peak_tready(m_ready),
        .s_axis_peak_tvalid(pvalid), .peak_mag(pmag), .peak_index(pidx),
        .overflow(ovf)
    );

    caf_peak_detect #(
        .i_bits(IW), .q_bits(QW), .mag_bits(MW), .num_results(1), .index_bits(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_product_tvalid(s1_vld), .i(di1), .q(dq1),
        .m_axis_product_tready(tready1), .m_axis_peak_tready(m1_ready),
        .s_axis_peak_tvalid(pvalid1), .peak_mag(pmag1), .peak_index(pidx1),
        .overflow(ovf1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame contents as plain magnitudes, handshake as a pending flag.
    longint frame_q[$];
    bit     pending = 1'b0;
    bit     ovf_exp = 1'b0;
    int     cyc = 0;
    int     last_cyc = 0;
    longint exp_mag = 0;
    int     exp_idx = 0;

    function automatic longint magsq(input logic signed [IW-1:0] a, input logic signed [QW-1:0] b);
        longint x;
        longint y;
        x = a;
        y = b;
        return x * x + y * y;
    endfunction

    always @(posedge clk) begin
        bit ev, hs, acc;
        if (!rst_n) begin
            frame_q.delete();
            pending = 1'b0;
            ovf_exp = 1'b0;
        end else begin
            ev      = pending && (cyc >= last_cyc + 4);
            hs      = ev && m_ready;
            acc     = s_vld && !pending;
            ovf_exp = s_vld && pending;
            if (acc) begin
                frame_q.push_back(magsq(di, dq));
                if (frame_q.size() == NR) begin
                    exp_mag = frame_q[0];
                    exp_idx = 0;
                    for (int k = 1; k < NR; k++)
                        if (frame_q[k] > exp_mag) begin
                            exp_mag = frame_q[k];
                            exp_idx = k;
                        end
                    frame_q.delete();
                    pending  = 1'b1;
                    last_cyc = cyc + 1;
                end
            end
            if (hs) pending = 1'b0;
        end
        cyc++;
    end

    always @(negedge clk) begin
        bit ev;
        if (rst_n) begin
            ev = pending && (cyc >= last_cyc + 4);
            check("tready", 64'(tready), 64'(!pending));
            check("overflow", 64'(ovf), 64'(ovf_exp));
            check("peak_valid", 64'(pvalid), 64'(ev));
            if (ev && pvalid) begin
                check("peak_mag", 64'(pmag), 64'(exp_mag));
                check("peak_index", 64'(pidx), 64'(exp_idx));
            end
        end
    end

    logic signed [IW-1:0] fi [NR];
    logic signed [QW-1:0] fq [NR];

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic fill(input int vi, input int vq);
        for (int k = 0; k < NR; k++) begin
            fi[k] = IW'(vi);
            fq[k] = QW'(vq);
        end
    endtask

    task automatic wait_tready();
        int n = 0;
        while (!tready && n < 40) begin
            step();
            n++;
        end
        check("tready_timeout", 64'(tready), 64'd1);
    endtask

    task automatic send_frame(input int gaps);
        wait_tready();
        for (int k = 0; k < NR; k++) begin
            int g;
            g = int'($urandom_range(gaps, 0));
            s_vld = 1'b0;
            repeat (g) step();
            s_vld = 1'b1;
            di = fi[k];
            dq = fq[k];
            step();
        end
        s_vld = 1'b0;
    endtask

    task automatic wait_peak(input bit lit, input longint m, input int idx, input int hold);
        int n = 0;
        while (!pvalid && n < 20) begin
            step();
            n++;
        end
        check("peak_valid_timeout", 64'(pvalid), 64'd1);
        if (lit) begin
            check("lit_peak_mag", 64'(pmag), 64'(m));
            check("lit_peak_index", 64'(pidx), 64'(idx));
            check("model_mag", 64'(exp_mag), 64'(m));
        end
        for (int h = 0; h < hold; h++) begin
            s_vld = 1'b1;
            di = IW'($urandom);
            dq = QW'($urandom);
            step();
        end
        s_vld = 1'b0;
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
    endtask

    task automatic one_sample(input int vi, input int vq, input longint m);
        int n = 0;
        while (!tready1 && n < 20) begin
            step();
            n++;
        end
        check("n1_tready", 64'(tready1), 64'd1);
        s1_vld = 1'b1;
        di1 = IW'(vi);
        dq1 = QW'(vq);
        step();
        s1_vld = 1'b0;
        n = 0;
        while (!pvalid1 && n < 20) begin
            step();
            n++;
        end
        check("n1_valid", 64'(pvalid1), 64'd1);
        check("n1_latency", 64'(n), 64'd4);
        check("n1_peak_mag", 64'(pmag1), 64'(m));
        check("n1_peak_index", 64'(pidx1), 64'd0);
        m1_ready = 1'b1;
        step();
        m1_ready = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_tready", 64'(tready), 64'd1);
        check("rst_valid", 64'(pvalid), 64'd0);
        check("rst_peak_mag", 64'(pmag), 64'd0);
        check("rst_peak_index", 64'(pidx), 64'd0);
        check("rst_overflow", 64'(ovf), 64'd0);
        check("rst1_tready", 64'(tready1), 64'd1);
        check("rst1_valid", 64'(pvalid1), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        check_reset_values();
        rst_n = 1'b1;
        step();

        fill(1, 1);
        fi[9] = 3; fq[9] = 4;
        send_frame(0);
        wait_peak(1'b1, 25, 9, 0);

        fill(1, 1);
        fi[2] = 5; fq[2] = 5;
        fi[11] = 7; fq[11] = 1;
        fi[6] = 3; fq[6] = 4;
        send_frame(1);
        wait_peak(1'b1, 50, 2, 0);

        fill(1, 1);
        fi[0] = IW'(-(1 << 23)); fq[0] = QW'(-(1 << 23));
        send_frame(0);
        wait_peak(1'b1, 64'h8000_0000_0000, 0, 0);

        wait_tready();
        for (int k = 0; k < 7; k++) begin
            s_vld = 1'b1;
            di = 1000;
            dq = QW'(k);
            step();
        end
        s_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        step();
        step();
        rst_n = 1'b1;
        step();
        fill(1, 1);
        fi[3] = 100; fq[3] = 0;
        send_frame(0);
        wait_peak(1'b1, 10000, 3, 0);

        fill(2, 1);
        fi[12] = -40; fq[12] = 9;
        send_frame(0);
        wait_peak(1'b1, 1681, 12, 10);
        fill(1, 1);
        fi[5] = 7; fq[5] = 7;
        send_frame(0);
        wait_peak(1'b1, 98, 5, 0);

        m_ready = 1'b1;
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < NR; k++) begin
                fi[k] = IW'($urandom);
                fq[k] = QW'($urandom);
                if (f[0]) fq[k] = QW'(fi[k] >>> 12);
            end
            send_frame(f % 3);
            wait_peak(1'b0, 0, 0, 0);
            m_ready = 1'b1;
        end
        m_ready = 1'b0;
        repeat (8) step();

        one_sample(2, 0, 4);
        one_sample(0, 5, 25);
        one_sample(1, 1, 2);

        repeat (4) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
